// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the multi-cycle bitwise logic unit.
//   - OP_* : 2-bit operation encodings carried on the op ports
//   - state_t : control FSM states (ST_IDLE, ST_RUN)
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// ---------------------------------------------------------------------------
// logic_slice
// Purely combinational SLICE_W-bit bitwise operator.
// Ports:
//   a, b : slice operands
//   op   : operation select (OP_AND / OP_OR / OP_XOR / OP_NOR)
//   y    : slice result
// ---------------------------------------------------------------------------
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [1:0]         op,
  output logic [SLICE_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// ---------------------------------------------------------------------------
// logic_unit_seq
// Multi-cycle bitwise logic unit (AND / OR / XOR / NOR). Operands are
// captured on start and processed SLICE_W bits per clock, LSB slice first,
// through one shared logic_slice. The result and zero flag are registered
// and only change at completion, so partial slices are never visible.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   start  : request, sampled only while idle (busy=0)
//   op     : operation, captured with start
//   A, B   : WIDTH-bit operands, captured with start
//   busy   : operation in flight
//   done   : one-cycle pulse, result/zero valid from this cycle
//   result : last completed result
//   zero   : result == 0
//   parity : XOR-reduction of result (only when LOGIC_UNIT_PARITY_EN is
//            defined; accumulated slice by slice during RUN)
//
// Optional build macro: LOGIC_UNIT_PARITY_EN
// ---------------------------------------------------------------------------
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  generate
    if ((WIDTH % SLICE_W) != 0) begin : g_bad_cfg
      $error("logic_unit_seq: WIDTH must be a multiple of SLICE_W");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_op;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_done;

  logic               w_capture;
  logic               w_last;
  logic [SLICE_W-1:0] w_a_sl [NUM_SLICES];
  logic [SLICE_W-1:0] w_b_sl [NUM_SLICES];
  logic [SLICE_W-1:0] w_y;
  logic [WIDTH-1:0]   w_work_next;

  // Split captured operands into slices; the current one is picked by r_idx.
  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_split
      assign w_a_sl[gi] = r_a[gi*SLICE_W +: SLICE_W];
      assign w_b_sl[gi] = r_b[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  logic_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a  (w_a_sl[r_idx]),
    .b  (w_b_sl[r_idx]),
    .op (r_op),
    .y  (w_y)
  );

  // Work value with the current slice merged in. At the last slice this is
  // the complete result, so it is written straight into result.
  always_comb begin
    w_work_next = r_work;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_work_next[i*SLICE_W +: SLICE_W] = w_y;
      end
    end
  end

  // Next-state / control decode.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_idx == IDX_W'(NUM_SLICES - 1)) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_AND;
      r_idx    <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_a    <= A;
        r_b    <= B;
        r_op   <= op;
        r_idx  <= '0;
        r_work <= '0;
      end else if (r_state == ST_RUN) begin
        r_work <= w_work_next;
        r_idx  <= r_idx + IDX_W'(1);
        if (w_last) begin
          r_idx    <= '0;
          r_result <= w_work_next;
          r_zero   <= (w_work_next == '0);
          r_done   <= 1'b1;
        end
      end
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic r_par_acc;
  logic r_parity;

  // Running parity of the slices produced so far; published with result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par_acc <= 1'b0;
      r_parity  <= 1'b0;
    end else if (w_capture) begin
      r_par_acc <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_par_acc <= r_par_acc ^ (^w_y);
      if (w_last) begin
        r_parity <= r_par_acc ^ (^w_y);
      end
    end
  end

  assign parity = r_parity;
`endif

  assign busy   = (r_state == ST_RUN);
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;

endmodule
